// File: rtl/arf028b032e2r2w0cbbehraa4acw_wr_pkg.sv
// Shared constants and types for the latch-array write staging stage.
package arf028b032e2r2w0cbbehraa4acw_wr_pkg;

  localparam int unsigned NUM_ENTRIES = 28;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH  = 5;

  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(27);

  typedef enum logic {
    INIT,
    IDLE
  } state_e;

endpackage

// File: rtl/arf028b032e2r2w0cbbehraa4acw_wr_dec.sv
// Address to one-hot entry decode with an in-range flag.
module arf028b032e2r2w0cbbehraa4acw_wr_dec #(
  parameter int unsigned N  = 28,
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] addr_i,
  output logic [N-1:0]  onehot_o,
  output logic          in_range_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot_o[i] = (addr_i == AW'(i));
    end
    in_range_o = (32'(addr_i) < N);
  end

endmodule

// File: rtl/arf028b032e2r2w0cbbehraa4acw_wr_stage.sv
// Two-port write staging: registered one-hot enables and data for the latch
// array, same-entry collision resolution, and a clear-all sequencer.
module arf028b032e2r2w0cbbehraa4acw_wr_stage
  import arf028b032e2r2w0cbbehraa4acw_wr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             wr_en_i,
  input  logic [ADDR_WIDTH-1:0]  wr_addr0_i,
  input  logic [ADDR_WIDTH-1:0]  wr_addr1_i,
  input  logic [DATA_WIDTH-1:0]  wr_data0_i,
  input  logic [DATA_WIDTH-1:0]  wr_data1_i,
  input  logic                   init_req_i,
  output logic                   wr_ready_o,
  output logic                   init_busy_o,
  output logic [NUM_ENTRIES-1:0] arr_we0_o,
  output logic [NUM_ENTRIES-1:0] arr_we1_o,
  output logic [DATA_WIDTH-1:0]  arr_wdata0_o,
  output logic [DATA_WIDTH-1:0]  arr_wdata1_o,
  output logic                   collide_o,
  output logic                   addr_err_o
);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_ENTRIES-1:0] we0_q, we0_d, we1_q, we1_d;
  logic [DATA_WIDTH-1:0]  wdata0_q, wdata0_d, wdata1_q, wdata1_d;
  logic                   collide_q, collide_d;
  logic                   addr_err_q, addr_err_d;

  logic [NUM_ENTRIES-1:0] oh0, oh1, cnt_oh;
  logic                   in0, in1, cnt_in;
  logic                   v0, v1;

  arf028b032e2r2w0cbbehraa4acw_wr_dec #(.N(NUM_ENTRIES), .AW(ADDR_WIDTH)) u_dec0 (
    .addr_i     (wr_addr0_i),
    .onehot_o   (oh0),
    .in_range_o (in0)
  );

  arf028b032e2r2w0cbbehraa4acw_wr_dec #(.N(NUM_ENTRIES), .AW(ADDR_WIDTH)) u_dec1 (
    .addr_i     (wr_addr1_i),
    .onehot_o   (oh1),
    .in_range_o (in1)
  );

  // cnt never exceeds LAST_ENTRY, so its range flag is unused.
  arf028b032e2r2w0cbbehraa4acw_wr_dec #(.N(NUM_ENTRIES), .AW(ADDR_WIDTH)) u_dec_cnt (
    .addr_i     (cnt_q),
    .onehot_o   (cnt_oh),
    .in_range_o (cnt_in)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we0_d      = '0;
    we1_d      = '0;
    wdata0_d   = wdata0_q;
    wdata1_d   = wdata1_q;
    collide_d  = 1'b0;
    addr_err_d = addr_err_q;
    v0         = 1'b0;
    v1         = 1'b0;
    case (state_q)
      INIT: begin
        we0_d    = cnt_oh;
        wdata0_d = '0;
        if (cnt_q == LAST_ENTRY) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        v0        = wr_en_i[0] && in0;
        v1        = wr_en_i[1] && in1;
        collide_d = v0 && v1 && (wr_addr0_i == wr_addr1_i);
        if (v0 && !collide_d) we0_d = oh0;
        if (v1)               we1_d = oh1;
        if (v0) wdata0_d = wr_data0_i;
        if (v1) wdata1_d = wr_data1_i;
        if ((wr_en_i[0] && !in0) || (wr_en_i[1] && !in1)) addr_err_d = 1'b1;
        if (init_req_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      we0_q      <= '0;
      we1_q      <= '0;
      wdata0_q   <= '0;
      wdata1_q   <= '0;
      collide_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we0_q      <= we0_d;
      we1_q      <= we1_d;
      wdata0_q   <= wdata0_d;
      wdata1_q   <= wdata1_d;
      collide_q  <= collide_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign wr_ready_o   = (state_q == IDLE);
  assign init_busy_o  = (state_q == INIT);
  assign arr_we0_o    = we0_q;
  assign arr_we1_o    = we1_q;
  assign arr_wdata0_o = wdata0_q;
  assign arr_wdata1_o = wdata1_q;
  assign collide_o    = collide_q;
  assign addr_err_o   = addr_err_q;

  logic unused_cnt_in;
  assign unused_cnt_in = cnt_in;

endmodule
